// File: rtl/sw_conditioner.sv
// Switch-bank input conditioner: two-flop synchroniser, per-bit debounce,
// and a latched press event on the rising edge of the top (handshake) switch.
module sw_conditioner #(
  parameter int N_SW      = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw,
  output logic            stable_sw7,
  output logic            press_evt,
  input  logic            evt_ack,
  output logic            overrun
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_SW-1:0]            s1;
  logic [N_SW-1:0]            s2;
  logic [N_SW-1:0][CNT_W-1:0] cnt;
  logic [N_SW-1:0][CNT_W-1:0] cnt_next;
  logic [N_SW-1:0]            sw_next;
  logic                       rise;
  logic                       press_next;
  logic                       overrun_next;

  // Bring the asynchronous switch bank into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Per-bit debounce: a bit is accepted only after it has disagreed with the
  // current stable value for DB_CYCLES consecutive cycles; any agreeing cycle
  // restarts the count.
  always_comb begin
    sw_next  = sw;
    cnt_next = cnt;
    for (int i = 0; i < N_SW; i++) begin
      if (s2[i] == sw[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        sw_next[i]  = s2[i];
        cnt_next[i] = '0;
      end else begin
        cnt_next[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Press event bookkeeping, decided from the next-state switch value so the
  // event appears on the same edge as the debounced rise. A new rise beats an
  // acknowledge arriving on the same edge.
  always_comb begin
    rise         = sw_next[N_SW-1] & ~sw[N_SW-1];
    press_next   = press_evt;
    overrun_next = overrun;
    if (rise) begin
      press_next = 1'b1;
      if (press_evt && !evt_ack) begin
        overrun_next = 1'b1;
      end
    end else if (evt_ack) begin
      press_next = 1'b0;
    end
  end

  // Stable value, debounce counters and event flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw        <= '0;
      cnt       <= '0;
      press_evt <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sw        <= sw_next;
      cnt       <= cnt_next;
      press_evt <= press_next;
      overrun   <= overrun_next;
    end
  end

  assign stable_sw7 = sw[N_SW-1];

endmodule

// File: tb/tb_sw_conditioner.sv
// Directed bench for sw_conditioner: expectations are queued per clock edge
// when stimulus is applied and checked as each edge is reached.
module tb_sw_conditioner;

  logic       clk;
  logic       reset;
  logic [7:0] sw_raw;
  logic [7:0] sw;
  logic       stable_sw7;
  logic       press_evt;
  logic       evt_ack;
  logic       overrun;

  typedef struct {
    int         e;
    logic [7:0] sw;
    logic       press;
    logic       ovr;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   ecount = 0;
  int   tests  = 0;
  int   fails  = 0;

  sw_conditioner #(.N_SW(8), .DB_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .sw         (sw),
    .stable_sw7 (stable_sw7),
    .press_evt  (press_evt),
    .evt_ack    (evt_ack),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_at(input int e, input logic [7:0] s, input logic p,
                           input logic o, input string tag);
    exp_t x;
    x.e = e; x.sw = s; x.press = p; x.ovr = o; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic step();
    exp_t x;
    @(posedge clk);
    #1;
    ecount++;
    while (sb.size() > 0 && sb[0].e <= ecount) begin
      x = sb.pop_front();
      tests++;
      assert (sw === x.sw) else begin
        fails++;
        $error("FAIL %s sw @edge %0d: observed %h expected %h", x.tag, ecount, sw, x.sw);
      end
      tests++;
      assert (stable_sw7 === x.sw[7]) else begin
        fails++;
        $error("FAIL %s stable_sw7 @edge %0d: observed %b expected %b", x.tag, ecount, stable_sw7, x.sw[7]);
      end
      tests++;
      assert (press_evt === x.press) else begin
        fails++;
        $error("FAIL %s press_evt @edge %0d: observed %b expected %b", x.tag, ecount, press_evt, x.press);
      end
      tests++;
      assert (overrun === x.ovr) else begin
        fails++;
        $error("FAIL %s overrun @edge %0d: observed %b expected %b", x.tag, ecount, overrun, x.ovr);
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Change the raw bank and hold it: old value through E4, new value at E5.
  task automatic settle(input logic [7:0] nv, input logic [7:0] ov,
                        input logic pb, input logic ob,
                        input logic pa, input logic oa, input string tag);
    int e0;
    sw_raw = nv;
    e0 = ecount + 1;
    for (int k = 0; k <= 4; k++) expect_at(e0 + k, ov, pb, ob, tag);
    expect_at(e0 + 5, nv, pa, oa, tag);
    run(6);
  endtask

  initial begin
    int e0;
    reset   = 1'b1;
    sw_raw  = 8'hFF;
    evt_ack = 1'b0;

    // reset held with all switches high
    for (int k = 1; k <= 3; k++) expect_at(k, 8'h00, 1'b0, 1'b0, "reset_hold");
    run(3);
    reset = 1'b0;
    e0 = ecount + 1;
    for (int k = 0; k <= 4; k++) expect_at(e0 + k, 8'h00, 1'b0, 1'b0, "rst_release");
    expect_at(e0 + 5, 8'hFF, 1'b1, 1'b0, "rst_release_e5");
    run(6);
    evt_ack = 1'b1;
    expect_at(ecount + 1, 8'hFF, 1'b0, 1'b0, "ack_after_reset");
    run(1);
    evt_ack = 1'b0;

    // falling edges: no event; then latency of a multi-bit pattern
    settle(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, "fall_all");
    settle(8'h25, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "latency_25");

    // 3-cycle glitch on bit 3 is rejected
    sw_raw = 8'h2D;
    e0 = ecount + 1;
    for (int k = 0; k <= 8; k++) expect_at(e0 + k, 8'h25, 1'b0, 1'b0, "glitch3");
    run(3);
    sw_raw = 8'h25;
    run(7);

    // 4-cycle pulse on bit 3 passes for exactly 4 cycles
    sw_raw = 8'h2D;
    e0 = ecount + 1;
    for (int k = 0; k <= 4; k++) expect_at(e0 + k, 8'h25, 1'b0, 1'b0, "pulse4_pre");
    for (int k = 5; k <= 8; k++) expect_at(e0 + k, 8'h2D, 1'b0, 1'b0, "pulse4_high");
    for (int k = 9; k <= 10; k++) expect_at(e0 + k, 8'h25, 1'b0, 1'b0, "pulse4_post");
    run(4);
    sw_raw = 8'h25;
    run(7);

    // handshake: press then acknowledge
    settle(8'hA5, 8'h25, 1'b0, 1'b0, 1'b1, 1'b0, "press");
    evt_ack = 1'b1;
    expect_at(ecount + 1, 8'hA5, 1'b0, 1'b0, "ack_clear");
    run(1);
    evt_ack = 1'b0;
    expect_at(ecount + 1, 8'hA5, 1'b0, 1'b0, "ack_hold");
    run(1);

    // overrun: two presses without acknowledge
    settle(8'h25, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "rel1");
    settle(8'hA5, 8'h25, 1'b0, 1'b0, 1'b1, 1'b0, "press1");
    settle(8'h25, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, "rel2");
    settle(8'hA5, 8'h25, 1'b1, 1'b0, 1'b1, 1'b1, "press2");
    evt_ack = 1'b1;
    expect_at(ecount + 1, 8'hA5, 1'b0, 1'b1, "ovr_ack");
    run(1);
    evt_ack = 1'b0;
    for (int k = 1; k <= 3; k++) expect_at(ecount + k, 8'hA5, 1'b0, 1'b1, "ovr_sticky");
    run(3);

    // reset clears overrun; switch held high gives a fresh press
    reset = 1'b1;
    expect_at(ecount + 1, 8'h00, 1'b0, 1'b0, "reset_clear");
    run(1);
    reset = 1'b0;
    e0 = ecount + 1;
    for (int k = 0; k <= 4; k++) expect_at(e0 + k, 8'h00, 1'b0, 1'b0, "rst2_release");
    expect_at(e0 + 5, 8'hA5, 1'b1, 1'b0, "rst2_press");
    run(6);

    // collision: ack on the same edge as a new rise, event still pending
    settle(8'h25, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, "rel3");
    sw_raw = 8'hA5;
    e0 = ecount + 1;
    for (int k = 0; k <= 4; k++) expect_at(e0 + k, 8'h25, 1'b1, 1'b0, "coll_pre");
    run(5);
    evt_ack = 1'b1;
    expect_at(e0 + 5, 8'hA5, 1'b1, 1'b0, "collision");
    run(1);
    evt_ack = 1'b0;
    expect_at(ecount + 1, 8'hA5, 1'b1, 1'b0, "coll_after");
    run(1);

    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    if (sb.size() > 0) begin
      fails++;
      $error("FAIL drain: observed %0d expectations unchecked, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
